// File: rtl/proc_pkg.sv
// Shared definitions for the DRAM controller slice.
// Holds the controller FSM encoding, the default word/address widths and
// the width of the wait-state counter (WAIT_STATES is limited to 0..15).
package proc_pkg;

  localparam int unsigned DEF_ADDR_W = 18;
  localparam int unsigned DEF_DATA_W = 9;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_t;

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter for one ACCESS beat.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val (takes priority over dec)
//   load_val  - value to load
//   dec       - decrement while nonzero
//   zero      - counter currently equals zero
module wait_counter import proc_pkg::*; #(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dram_ctrl.sv
// Simple wait-stated DRAM access controller.
// A request sampled in IDLE runs one ACCESS phase of WAIT_STATES+1 cycles
// per beat, followed by a one-cycle DONE phase that pulses ack.
// Optional feature macro: DRAM_CTRL_BURST_EN adds burst_len (beats = burst_len+1,
// incrementing word address with wrap-around).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req, we, addr       - request, direction, start address (sampled in IDLE)
//   wdata               - write data, sampled on entry to each beat's ACCESS
//   burst_len           - (DRAM_CTRL_BURST_EN only) extra beats
//   rdata, ack, busy    - read data, per-beat completion pulse, not-IDLE flag
//   mem_write, mem_addr, mem_din, mem_dout - DRAM interface
module dram_ctrl import proc_pkg::*; #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef DRAM_CTRL_BURST_EN
  input  logic [1:0]        burst_len,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_STATES);

  state_t            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        beats_q;   // beats still to run after the current one
  logic              ack_q;
  logic              busy_q;
  logic [1:0]        beats_req;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

`ifdef DRAM_CTRL_BURST_EN
  assign beats_req = burst_len;
`else
  assign beats_req = 2'd0;
`endif

  // Counter reloads whenever a beat's ACCESS phase is about to begin.
  assign cnt_load = ((state_q == StIdle) && req) || ((state_q == StDone) && (beats_q != 2'd0));
  assign cnt_dec  = (state_q == StAccess);

  wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WaitInit),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      beats_q <= 2'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            din_q   <= wdata;
            beats_q <= beats_req;
            busy_q  <= 1'b1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_zero) begin
            if (!we_q) begin
              rdata_q <= mem_dout;
            end
            ack_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          ack_q <= 1'b0;
          if (beats_q != 2'd0) begin
            addr_q  <= addr_q + 1'b1;
            din_q   <= wdata;
            beats_q <= beats_q - 1'b1;
            state_q <= StAccess;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Decoded purely from registers, so it drops as soon as rst clears the state.
  assign mem_write = (state_q == StAccess) && cnt_zero && we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a schedule-based reference model (cycle arithmetic on
// beat period WAIT_STATES+2) checked every cycle, plus directed literal checks.
// A second instance with WAIT_STATES=0 covers the minimum-latency read.
module tb_dram_ctrl;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 9;
  localparam int W = 1;
  localparam int P = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WAIT_STATES=1)
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
`ifdef DRAM_CTRL_BURST_EN
  logic [1:0]    bl = 2'd0;
`endif
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic          ack, busy, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] dram   [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  // Zero-wait instance
  logic          req0 = 1'b0, we0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] rdata0, mem_din0, mem_dout0;
  logic          ack0, busy0, mem_write0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] dram0 [0:(1<<AW)-1];

  dram_ctrl #(.WAIT_STATES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DRAM_CTRL_BURST_EN
    .burst_len(bl),
`endif
    .rdata(rdata), .ack(ack), .busy(busy), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  dram_ctrl #(.WAIT_STATES(0), .ADDR_W(AW), .DATA_W(DW)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DRAM_CTRL_BURST_EN
    .burst_len(2'd0),
`endif
    .rdata(rdata0), .ack(ack0), .busy(busy0), .mem_write(mem_write0),
    .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_dout(mem_dout0)
  );

  assign mem_dout  = dram[mem_addr];
  assign mem_dout0 = dram0[mem_addr0];
  always @(posedge clk) if (mem_write) dram[mem_addr] <= mem_din;
  always @(posedge clk) if (mem_write0) dram0[mem_addr0] <= mem_din0;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request at edge e0 owns cycles
  // [e0, e0 + beats*P); within beat b, cycle offset W is the final ACCESS
  // cycle and offset W+1 is the ack cycle.
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_e0 = 0, m_free = 0, mk = 0, m_beats = 1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_base = '0, m_addr = '0;
  logic [DW-1:0] m_din = '0, e_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act   = 1'b0;
      m_addr  = '0;
      m_din   = '0;
      e_rdata = '0;
    end else begin
      mk = cyc;
      if (m_act && mk >= m_e0 && mk < m_free) begin
        if ((mk - m_e0) % P == W) begin
          if (m_we) shadow[m_addr] = m_din;
          else e_rdata = shadow[m_addr];
        end
      end else if (req) begin
        m_act  = 1'b1;
        m_e0   = mk + 1;
        m_we   = we;
        m_base = addr;
`ifdef DRAM_CTRL_BURST_EN
        m_beats = int'(bl) + 1;
`else
        m_beats = 1;
`endif
        m_free = m_e0 + m_beats * P;
      end
      if (m_act && mk + 1 >= m_e0 && mk + 1 < m_free && (mk + 1 - m_e0) % P == 0) begin
        m_addr = m_base + AW'((mk + 1 - m_e0) / P);
        m_din  = wdata;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit e_busy;
    int ph;
    if (ack) n_ack++;
    if (!rst) begin
      e_busy = m_act && cyc >= m_e0 && cyc < m_free;
      ph = e_busy ? (cyc - m_e0) % P : -1;
      chk("busy",      busy,      e_busy);
      chk("ack",       ack,       ph == W + 1);
      chk("mem_write", mem_write, e_busy && m_we && ph == W);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_din",   mem_din,   m_din);
      chk("rdata",     rdata,     e_rdata);
    end
  end

  task automatic start(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] l);
    @(posedge clk);
    #1;
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef DRAM_CTRL_BURST_EN
    bl = l;
`else
    if (l != 2'd0) $display("note: burst_len ignored in single-beat build");
`endif
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  int a0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dram[i] = '0; shadow[i] = '0; dram0[i] = '0;
    end
    dram0[5] = 9'h123;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait read: ACCESS one cycle, ack the next, busy two cycles
    @(posedge clk); #1 req0 = 1'b1; addr0 = 18'h5;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    chk("ws0_c0_busy", busy0, 1); chk("ws0_c0_ack", ack0, 0);
    @(negedge clk);
    chk("ws0_c1_busy", busy0, 1); chk("ws0_c1_ack", ack0, 1); chk("ws0_rdata", rdata0, 9'h123);
    @(negedge clk);
    chk("ws0_c2_busy", busy0, 0); chk("ws0_c2_ack", ack0, 0);

    // Write 0x1A5 to 0x00010
    start(1'b1, 18'h00010, 9'h1A5, 2'd0);
    @(negedge clk); chk("wr_c0_mw", mem_write, 0); chk("wr_c0_busy", busy, 1);
    @(negedge clk); chk("wr_c1_mw", mem_write, 1); chk("wr_c1_addr", mem_addr, 18'h00010);
    @(negedge clk); chk("wr_c2_ack", ack, 1); chk("wr_c2_mw", mem_write, 0);
    @(negedge clk); chk("wr_c3_busy", busy, 0); chk("wr_c3_ack", ack, 0);
    chk("wr_dram", dram[18'h00010], 9'h1A5);

    // Read back, then a write elsewhere must not disturb rdata
    start(1'b0, 18'h00010, 9'h000, 2'd0);
    repeat (3) @(negedge clk);
    chk("rd_ack", ack, 1); chk("rd_rdata", rdata, 9'h1A5);
    @(negedge clk);
    start(1'b1, 18'h00020, 9'h0F0, 2'd0);
    repeat (4) @(negedge clk);
    chk("rd_hold_rdata", rdata, 9'h1A5); chk("wr2_dram", dram[18'h00020], 9'h0F0);

    // req held through busy with a different address: one access only
    a0 = n_ack;
    @(posedge clk); #1 req = 1'b1; we = 1'b1; addr = 18'h00030; wdata = 9'h111;
    @(posedge clk); #1 addr = 18'h00031; wdata = 9'h1FF;
    repeat (P) @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_acks", n_ack - a0, 1);
    chk("held_dram30", dram[18'h00030], 9'h111);
    chk("held_dram31", dram[18'h00031], 9'h000);

`ifdef DRAM_CTRL_BURST_EN
    // Four-beat write wrapping the top of the address space
    a0 = n_ack;
    start(1'b1, 18'h3FFFE, 9'h001, 2'd3);
    wdata = 9'h002;
    repeat (P) @(posedge clk); #1 wdata = 9'h003;
    repeat (P) @(posedge clk); #1 wdata = 9'h004;
    repeat (2 * P) @(posedge clk);
    @(negedge clk);
    chk("burst_acks", n_ack - a0, 4);
    chk("burst_d0", dram[18'h3FFFE], 9'h001);
    chk("burst_d1", dram[18'h3FFFF], 9'h002);
    chk("burst_d2", dram[18'h00000], 9'h003);
    chk("burst_d3", dram[18'h00001], 9'h004);
    bl = 2'd0;
`endif

    // Reset during the final ACCESS cycle of a write
    start(1'b1, 18'h00040, 9'h0AA, 2'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_mw", mem_write, 0); chk("abort_ack", ack, 0); chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("abort_dram", dram[18'h00040], 9'h000);

    // Operation resumes from IDLE after the abort
    start(1'b0, 18'h00010, 9'h000, 2'd0);
    repeat (3) @(negedge clk);
    chk("resume_ack", ack, 1); chk("resume_rdata", rdata, 9'h1A5);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning extra ACCESS cycles per beat (0..15).
REQ-002 SHALL have parameter ADDR_W, default 18, meaning word-address width.
REQ-003 SHALL have parameter DATA_W, default 9, meaning word width.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  1  requester access request, sampled in IDLE only.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr  input  ADDR_W  start word address; sampled with req.
REQ-009 SHALL have port wdata  input  DATA_W  write data; sampled at each beat's ACCESS entry.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data.
REQ-011 SHALL have port ack  output  1  one-cycle pulse per completed beat.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports mem_write (output, 1), mem_addr (output, ADDR_W), mem_din (output, DATA_W), mem_dout (input, DATA_W) to the DRAM; DRAM reads combinationally, writes on clk rising edge.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE: req=1 at edge E0 SHALL capture we, addr, wdata, load wait counter with WAIT_STATES, enter ACCESS.
REQ-016 ACCESS: SHALL drive mem_addr and mem_din from captured registers; decrement counter while nonzero; stay WAIT_STATES+1 cycles total.
REQ-017 Final ACCESS cycle: write SHALL assert mem_write for exactly that cycle; read SHALL latch mem_dout into rdata at its closing edge.
REQ-018 mem_write SHALL be 0 in every other cycle and state.
REQ-019 ACCESS SHALL exit to DONE at edge E0+WAIT_STATES+1; ack SHALL be 1 only during DONE.
REQ-020 DONE with no beats remaining SHALL return to IDLE; req in DONE SHALL be ignored (a new access starts no earlier than the following IDLE cycle).
REQ-021 req while busy=1 SHALL be ignored without side effects.
REQ-022 rdata SHALL hold its value until the next read beat completes; writes SHALL not alter rdata.
REQ-023 mem_addr/mem_din SHALL hold last driven values in IDLE.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, counter 0, beat count 0, rdata 0, ack 0, busy 0, mem_write 0, mem_addr 0, mem_din 0.
REQ-025 Reset mid-access SHALL abort with no further mem_write and no ack; release resumes in IDLE.

Configuration
REQ-026 Macro DRAM_CTRL_BURST_EN SHALL, when defined, add input burst_len (2 bits, sampled with req; beats = burst_len+1).
REQ-027 With the macro: DONE with beats remaining SHALL increment the address (mod 2^ADDR_W, 2^ADDR_W-1 wraps to 0), resample wdata, reload the counter and re-enter ACCESS; busy stays 1 across beats.
REQ-028 Without the macro: no burst_len port, every access exactly one beat.

Structure
REQ-029 FSM state encoding and DATA_W/ADDR_W defaults SHALL live in shared package proc_pkg.
REQ-030 Wait-state counter SHALL be sub-module wait_counter (load, decrement, zero flag); all else in dram_ctrl.

Verification
REQ-031 WAIT_STATES=1: write req addr=0x00010, wdata=0x1A5 -> mem_write high 1 cycle at edge E0+2, ack at E0+2..E0+3, DRAM[0x00010]=0x1A5.
REQ-032 Read back addr=0x00010 -> rdata=0x1A5 when ack rises; rdata stays 0x1A5 through a following write.
REQ-033 WAIT_STATES=0: read -> ack pulse in cycle after ACCESS (2 cycles after req sampled), busy high 2 cycles.
REQ-034 req held high during busy with differing addr -> ignored; only one ack, DRAM unchanged at that addr.
REQ-035 BURST_EN, burst_len=3, write addr=0x3FFFE, wdata 0x001..0x004 -> writes to 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; four ack pulses.
REQ-036 rst asserted in ACCESS of a write -> mem_write, ack, busy low immediately; target DRAM word unchanged.
